// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit_mc
// Purpose  : Forwarding, load-use, branch-flush and multi-cycle EX hold
//            control for the 5-stage RISC-V pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit_mc #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = $clog2(MC_LATENCY) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [1:0]            ResultSrcE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  PCSrcE,
  input  logic                  MultiCycleE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  McBusy,
  output logic                  McDoneE
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0]       c_FWD_RD1     = 2'b00;
  localparam logic [1:0]       c_FWD_RESULTW = 2'b01;
  localparam logic [1:0]       c_FWD_ALUM    = 2'b10;
  localparam logic [1:0]       c_SRC_LOAD    = 2'b01;
  localparam bit               c_MC_STALLS   = (MC_LATENCY > 1);
  // The IDLE detection cycle is the first EX cycle, hence the -2 preload.
  localparam logic [CNT_W-1:0] c_CNT_LOAD    = (MC_LATENCY > 1) ? CNT_W'(MC_LATENCY - 2) : '0;

  state_t           r_state;
  state_t           w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_mcStall;
  logic             w_mcDone;
  logic             w_busy;
  logic             w_lwStall;
  logic [1:0]       w_fwdA;
  logic [1:0]       w_fwdB;

  function automatic logic [1:0] fwdSel(input logic [REG_ADDR_W-1:0] rs);
    if (RegWriteM && (RdM == rs) && (rs != '0))
      return c_FWD_ALUM;
    else if (RegWriteW && (RdW == rs) && (rs != '0))
      return c_FWD_RESULTW;
    else
      return c_FWD_RD1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_mcStall   = 1'b0;
    w_mcDone    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (MultiCycleE) begin
          if (c_MC_STALLS) begin
            w_mcStall   = 1'b1;
            w_stateNext = ST_BUSY;
            w_cntNext   = c_CNT_LOAD;
          end else begin
            w_mcDone = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (r_cnt != '0) begin
          w_mcStall = 1'b1;
          w_cntNext = r_cnt - CNT_W'(1);
        end else begin
          w_mcDone    = 1'b1;
          w_stateNext = ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  assign w_busy    = (r_state == ST_BUSY);
  // A load hazard during BUSY belongs to an instruction already frozen in ID.
  assign w_lwStall = (ResultSrcE == c_SRC_LOAD) && ((Rs1D == RdE) || (Rs2D == RdE))
                     && (RdE != '0) && !w_busy;
  assign w_fwdA    = fwdSel(Rs1E);
  assign w_fwdB    = fwdSel(Rs2E);

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    McBusy    = 1'b0;
    McDoneE   = 1'b0;
    if (reset) begin
      ForwardAE = w_fwdA;
      ForwardBE = w_fwdB;
      StallF    = w_lwStall | w_mcStall;
      StallD    = w_lwStall | w_mcStall;
      StallE    = w_mcStall;
      FlushM    = w_mcStall;
      // A frozen EX op must not be flushed out from under itself.
      FlushE    = (w_lwStall | PCSrcE) & ~w_mcStall;
      FlushD    = PCSrcE & ~w_mcStall;
      McBusy    = w_busy;
      McDoneE   = w_mcDone;
    end
  end

endmodule
`default_nettype wire
